// File: rtl/uart_host_link_if.sv
// uart_host_link_if: groups the byte-stream, event-word and gesture signals
// of uart_host_link.
//   rx_data/rx_valid         received UART byte and its one-cycle strobe
//   tx_data/tx_valid/tx_busy transmit byte, one-cycle strobe, transmitter busy
//   evt_word/evt_valid/evt_ready  assembled event word towards the core
//   gesture_class/gesture_conf/gesture_valid  detection result strobe
// Handshake: evt_word is transferred on a cycle where evt_valid and evt_ready
// are both high; evt_valid and evt_word stay stable until then. rx_valid,
// tx_valid and gesture_valid are single-cycle strobes with no back-pressure;
// tx_busy is the transmitter's flow control and rises the cycle after tx_valid.
interface uart_host_link_if #(
  parameter int WORD_BYTES = 4,
  parameter int CLASS_W    = 2,
  parameter int CONF_W     = 4
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_busy;
  logic [8*WORD_BYTES-1:0] evt_word;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [CLASS_W-1:0]      gesture_class;
  logic [CONF_W-1:0]       gesture_conf;
  logic                    gesture_valid;

  modport master (
    output rx_data, rx_valid, tx_busy, evt_ready,
           gesture_class, gesture_conf, gesture_valid,
    input  tx_data, tx_valid, evt_word, evt_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy, evt_ready,
           gesture_class, gesture_conf, gesture_valid,
    output tx_data, tx_valid, evt_word, evt_valid
  );
endinterface

// File: rtl/uart_host_link.sv
// uart_host_link: bridges a UART byte stream to a host core.
//   RX side assembles WORD_BYTES bytes (MSB first) into evt_word, recognises
//   0xFC-0xFF as commands when they start a word after a long idle gap, and
//   discards partial words after a long idle timeout.
//   TX side queues 1- or 2-byte messages (gesture reports, command replies)
//   in a small FIFO and paces them out against tx_busy.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   bus (slave)         rx/tx/event/gesture signals, see uart_host_link_if
//   status_byte         reply content for command 0xFE
//   cfg_byte0/1         reply content for command 0xFD
//   soft_rst            one-cycle soft-reset request (command 0xFC)
//   evt_drop_count      words lost while evt_valid was pending (saturating)
//   resync_count        partial words discarded by timeout (saturating)
//   msg_drop_count      TX messages lost to a full FIFO (saturating)
//   dbg_tx_state        current TX FSM state
module uart_host_link #(
  parameter int WORD_BYTES     = 4,
  parameter int CMD_GAP_CYCLES = 2080,
  parameter int RESYNC_CYCLES  = 4160,
  parameter int MSG_FIFO_DEPTH = 4,
  parameter int CLASS_W        = 2,
  parameter int CONF_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_host_link_if.slave  bus,
  input  logic [7:0]       status_byte,
  input  logic [7:0]       cfg_byte0,
  input  logic [7:0]       cfg_byte1,
  output logic             soft_rst,
  output logic [7:0]       evt_drop_count,
  output logic [7:0]       resync_count,
  output logic [7:0]       msg_drop_count,
  output logic [1:0]       dbg_tx_state
);
  localparam int W        = 8 * WORD_BYTES;
  localparam int IDLE_MAX = (CMD_GAP_CYCLES > RESYNC_CYCLES) ? CMD_GAP_CYCLES : RESYNC_CYCLES;
  localparam int IW       = $clog2(IDLE_MAX + 1);
  localparam int XW       = $clog2(WORD_BYTES);
  localparam int AW       = $clog2(MSG_FIFO_DEPTH);
  localparam int MW       = 17;  // {two_bytes, byte0, byte1}

  typedef enum logic [1:0] {TX_IDLE, TX_W0, TX_B1, TX_W1} tx_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + 9'(n);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // ---------------- RX path ----------------
  logic [IW-1:0] r_idle;
  logic [XW-1:0] r_idx;
  logic [W-9:0]  r_asm;
  logic [W-1:0]  r_evt_word;
  logic          r_evt_valid;
  logic [7:0]    r_evt_drop, r_resync;
  logic          r_soft_rst;

  logic          w_cmd_ok, w_is_cmd, w_data_byte, w_word_done, w_timeout;
  logic [W-1:0]  w_word;

  assign w_cmd_ok    = (r_idle >= IW'(CMD_GAP_CYCLES));
  assign w_is_cmd    = bus.rx_valid && (r_idx == '0) && w_cmd_ok && (bus.rx_data >= 8'hFC);
  assign w_data_byte = bus.rx_valid && !w_is_cmd;
  assign w_word_done = w_data_byte && (r_idx == XW'(WORD_BYTES - 1));
  assign w_timeout   = !bus.rx_valid && (r_idx != '0) && (r_idle == IW'(RESYNC_CYCLES));
  assign w_word      = {r_asm, bus.rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle      <= IW'(IDLE_MAX);  // saturated so a command is accepted right after reset
      r_idx       <= '0;
      r_asm       <= '0;
      r_evt_word  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_drop  <= '0;
      r_resync    <= '0;
      r_soft_rst  <= 1'b0;
    end else begin
      if (bus.rx_valid)                   r_idle <= '0;
      else if (r_idle != IW'(IDLE_MAX))   r_idle <= r_idle + 1'b1;

      if (w_timeout) begin
        r_idx    <= '0;
        r_resync <= sat_add(r_resync, 2'd1);
      end else if (w_data_byte) begin
        r_asm <= w_word[W-9:0];
        r_idx <= w_word_done ? '0 : r_idx + 1'b1;
      end

      // A completed word may replace the pending one only when it is taken this cycle.
      if (w_word_done && (!r_evt_valid || bus.evt_ready)) begin
        r_evt_word  <= w_word;
        r_evt_valid <= 1'b1;
      end else if (r_evt_valid && bus.evt_ready) begin
        r_evt_valid <= 1'b0;
      end
      if (w_word_done && r_evt_valid && !bus.evt_ready)
        r_evt_drop <= sat_add(r_evt_drop, 2'd1);

      r_soft_rst <= w_is_cmd && (bus.rx_data == 8'hFC);
    end
  end

  // ---------------- message sources ----------------
  logic [MW-1:0] w_cmd_msg, w_gest_msg;
  logic          w_cmd_q;

  always_comb begin
    w_cmd_msg = '0;
    case (bus.rx_data)
      8'hFF:   w_cmd_msg = {1'b0, 8'h55, 8'h00};
      8'hFE:   w_cmd_msg = {1'b0, status_byte, 8'h00};
      8'hFD:   w_cmd_msg = {1'b1, cfg_byte0, cfg_byte1};
      default: w_cmd_msg = '0;
    endcase
  end
  assign w_cmd_q    = w_is_cmd && (bus.rx_data != 8'hFC);
  assign w_gest_msg = {1'b1, 4'hA, 4'(bus.gesture_class), 8'(bus.gesture_conf)};

  // One FIFO write per cycle: pending slot first, then gesture, then command.
  // Whatever loses is parked in the pending slot; only a third simultaneous
  // source is lost.
  logic          r_pend_valid;
  logic [MW-1:0] r_pend_msg;
  logic          w_wr_en, w_pend_set, w_lost;
  logic [MW-1:0] w_wr_msg, w_pend_msg;

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_msg   = '0;
    w_pend_set = 1'b0;
    w_pend_msg = '0;
    w_lost     = 1'b0;
    if (r_pend_valid) begin
      w_wr_en  = 1'b1;
      w_wr_msg = r_pend_msg;
      if (bus.gesture_valid) begin
        w_pend_set = 1'b1;
        w_pend_msg = w_gest_msg;
        w_lost     = w_cmd_q;
      end else if (w_cmd_q) begin
        w_pend_set = 1'b1;
        w_pend_msg = w_cmd_msg;
      end
    end else if (bus.gesture_valid) begin
      w_wr_en    = 1'b1;
      w_wr_msg   = w_gest_msg;
      w_pend_set = w_cmd_q;
      w_pend_msg = w_cmd_msg;
    end else if (w_cmd_q) begin
      w_wr_en  = 1'b1;
      w_wr_msg = w_cmd_msg;
    end
  end

  // ---------------- message FIFO ----------------
  logic [MW-1:0] r_fifo [MSG_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_msg_drop;
  logic          w_full, w_empty, w_pop, w_wr_ok, w_wr_drop;
  logic [MW-1:0] w_head;

  assign w_full    = (r_count == (AW+1)'(MSG_FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_wr_ok   = w_wr_en && (!w_full || w_pop);
  assign w_wr_drop = w_wr_en && !w_wr_ok;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_fifo[r_wr_ptr] <= w_wr_msg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_msg   <= '0;
      r_msg_drop   <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pend_valid <= w_pend_set;
      if (w_pend_set) r_pend_msg <= w_pend_msg;
      if (w_wr_drop || w_lost)
        r_msg_drop <= sat_add(r_msg_drop, 2'(w_wr_drop) + 2'(w_lost));
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t r_state, w_next;
  logic       r_tx_valid, r_len2, w_fire;
  logic [7:0] r_tx_data, r_b1, w_byte;

  always_ff @(posedge clk) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_fire = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      TX_IDLE: if (!w_empty && !bus.tx_busy) begin
        w_pop  = 1'b1;
        w_fire = 1'b1;
        w_byte = w_head[15:8];
        w_next = TX_W0;
      end
      TX_W0: if (bus.tx_busy) w_next = r_len2 ? TX_B1 : TX_IDLE;
      TX_B1: if (!bus.tx_busy) begin
        w_fire = 1'b1;
        w_byte = r_b1;
        w_next = TX_W1;
      end
      TX_W1: if (bus.tx_busy) w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_len2     <= 1'b0;
      r_b1       <= '0;
    end else begin
      r_tx_valid <= w_fire;
      if (w_fire) r_tx_data <= w_byte;
      if (w_pop) begin
        r_len2 <= w_head[16];
        r_b1   <= w_head[7:0];
      end
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.evt_word    = r_evt_word;
  assign bus.evt_valid   = r_evt_valid;
  assign soft_rst        = r_soft_rst;
  assign evt_drop_count  = r_evt_drop;
  assign resync_count    = r_resync;
  assign msg_drop_count  = r_msg_drop;
  assign dbg_tx_state    = r_state;
endmodule

// File: tb/tb_uart_host_link.sv
module tb_uart_host_link;
  logic       clk;
  logic       rst;
  logic [7:0] status_byte, cfg_byte0, cfg_byte1;
  logic       soft_rst;
  logic [7:0] evt_drop_count, resync_count, msg_drop_count;
  logic [1:0] dbg_tx_state;

  uart_host_link_if #(.WORD_BYTES(4), .CLASS_W(2), .CONF_W(4)) bus();

  uart_host_link #(
    .WORD_BYTES(4), .CMD_GAP_CYCLES(2080), .RESYNC_CYCLES(4160),
    .MSG_FIFO_DEPTH(4), .CLASS_W(2), .CONF_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .status_byte(status_byte), .cfg_byte0(cfg_byte0), .cfg_byte1(cfg_byte1),
    .soft_rst(soft_rst), .evt_drop_count(evt_drop_count),
    .resync_count(resync_count), .msg_drop_count(msg_drop_count),
    .dbg_tx_state(dbg_tx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int soft_cnt = 0;
  int tx_viol  = 0;
  logic hold_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // transmitter model: busy for a few cycles after every tx_valid
  initial begin
    int  cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_valid) begin
        tx_q.push_back(bus.tx_data);
        cnt = 4;
        if (prev) tx_viol++;
      end
      prev = bus.tx_valid;
      bus.tx_busy = hold_busy || (cnt > 0);
      if (cnt > 0) cnt--;
      if (soft_rst) soft_cnt++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic accept();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic gesture(input logic [1:0] c, input logic [3:0] f);
    bus.gesture_class = c;
    bus.gesture_conf  = f;
    bus.gesture_valid = 1'b1;
    @(negedge clk);
    bus.gesture_valid = 1'b0;
  endtask

  // wait for the expected bytes, then compare them in order
  task automatic check_tx(input string tag);
    int b;
    int n;
    b = 0;
    n = exp_q.size();
    while (tx_q.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_count"}, 64'(tx_q.size()), 64'(n));
    while (exp_q.size() > 0) begin
      if (tx_q.size() > 0) check(tag, 64'(tx_q.pop_front()), 64'(exp_q.pop_front()));
      else check({tag, "_missing"}, 64'h100, 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.evt_ready = 1'b0;
    bus.gesture_class = '0;
    bus.gesture_conf = '0;
    bus.gesture_valid = 1'b0;
    status_byte = 8'h00;
    cfg_byte0 = 8'h14;
    cfg_byte1 = 8'h08;
    idle(3);

    // reset state
    check("rst_evt_valid", 64'(bus.evt_valid), 64'd0);
    check("rst_evt_word", 64'(bus.evt_word), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_soft_rst", 64'(soft_rst), 64'd0);
    check("rst_counters", {40'd0, evt_drop_count, resync_count, msg_drop_count}, 64'd0);
    check("rst_tx_state", 64'(dbg_tx_state), 64'd0);
    rst = 1'b0;

    // basic word assembly, held until accepted
    idle(2100);
    send_word(32'h12345678);
    check("word1", 64'(bus.evt_word), 64'h12345678);
    check("word1_valid", 64'(bus.evt_valid), 64'd1);
    idle(5);
    check("word1_hold", 64'(bus.evt_valid), 64'd1);
    accept();
    check("word1_taken", 64'(bus.evt_valid), 64'd0);

    // commands: config reply, ping, soft reset
    tx_q.delete();
    idle(2100);
    send_byte(8'hFD);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h08);
    check_tx("cfg_reply");
    idle(2100);
    send_byte(8'hFF);
    exp_q.push_back(8'h55);
    check_tx("ping_reply");
    soft_cnt = 0;
    idle(2100);
    send_byte(8'hFC);
    idle(3);
    check("soft_rst_pulse", 64'(soft_cnt), 64'd1);

    // without the idle gap, command codes are plain data
    send_word(32'hFCFDFEFF);
    check("cmd_as_data", 64'(bus.evt_word), 64'hFCFDFEFF);
    idle(20);
    check("cmd_as_data_no_tx", 64'(tx_q.size()), 64'd0);
    check("cmd_as_data_no_srst", 64'(soft_cnt), 64'd1);
    accept();

    // overrun: second word lost while first is pending
    send_word(32'h11223344);
    send_word(32'h55667788);
    check("overrun_word", 64'(bus.evt_word), 64'h11223344);
    check("evt_drop", 64'(evt_drop_count), 64'd1);
    accept();
    check("overrun_taken", 64'(bus.evt_valid), 64'd0);

    // resync timeout discards partial word
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(5000);
    check("resync_count", 64'(resync_count), 64'd1);
    send_word(32'h01020304);
    check("resync_word", 64'(bus.evt_word), 64'h01020304);
    check("resync_once", 64'(resync_count), 64'd1);
    accept();

    // gesture and status command in the same cycle
    status_byte = 8'h5A;
    idle(2100);
    bus.gesture_class = 2'd3;
    bus.gesture_conf  = 4'd9;
    bus.gesture_valid = 1'b1;
    bus.rx_data  = 8'hFE;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.gesture_valid = 1'b0;
    bus.rx_valid = 1'b0;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h5A);
    check_tx("gest_cmd");

    // FIFO overflow with the transmitter held busy
    idle(20);
    hold_busy = 1'b1;
    idle(3);
    for (int i = 0; i < 6; i++) gesture(2'(i), 4'(i));
    idle(5);
    check("msg_drop", 64'(msg_drop_count), 64'd2);
    check("held_no_tx", 64'(tx_q.size()), 64'd0);
    hold_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA0 | 8'(i));
      exp_q.push_back(8'(i));
    end
    check_tx("fifo_drain");
    idle(50);
    check("fifo_no_extra", 64'(tx_q.size()), 64'd0);

    // reset mid-word abandons the partial word and clears counters
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1;
    idle(2);
    check("rst2_counters", {40'd0, evt_drop_count, resync_count, msg_drop_count}, 64'd0);
    check("rst2_evt_valid", 64'(bus.evt_valid), 64'd0);
    check("rst2_tx_valid", 64'(bus.tx_valid), 64'd0);
    rst = 1'b0;
    send_byte(8'hFF);
    exp_q.push_back(8'h55);
    check_tx("post_rst_ping");
    send_word(32'hCAFEBABE);
    check("post_rst_word", 64'(bus.evt_word), 64'hCAFEBABE);
    check("tx_valid_spacing", 64'(tx_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
